fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter that merges NREQ word streams into one FIFO write port.
// A grant is held for a whole packet or until MAX_BURST words, whichever ends first.
module fifo_wr_arbiter #(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ-1:0]       in_last,
  input  logic [NREQ*DSIZE-1:0] in_data,
  output logic [NREQ-1:0]       in_ready,
  output logic [NREQ-1:0]       gnt,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  input  logic                  wfull,
  output logic [15:0]           words_wr
);

  localparam int          GW = $clog2(NREQ);
  localparam int          CW = $clog2(MAX_BURST) + 1;
  localparam int unsigned NR = NREQ;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]      r_state;
  logic [GW-1:0]   r_g;
  logic [GW-1:0]   r_p;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [15:0]     r_words_wr;

  logic            w_busy;
  logic            w_acc;
  logic            w_end;
  logic            w_found;
  logic [GW-1:0]   w_cand;
  logic [GW-1:0]   w_sel;
  logic [NREQ-1:0] w_sel_onehot;

  // Search starts just after the last-served requester, so it becomes lowest priority.
  always_comb begin
    w_sel   = r_p;
    w_cand  = r_p;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= NR; k++) begin
      w_cand = GW'((32'(r_p) + k) % NR);
      if (!w_found && in_valid[w_cand]) begin
        w_sel   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;

  assign w_busy = (r_state == ST_BUSY);
  assign w_acc  = w_busy & in_valid[r_g] & ~wfull;
  assign w_end  = in_last[r_g] | (r_cnt == CW'(MAX_BURST - 1));

  assign gnt      = r_gnt;
  assign in_ready = (w_busy & ~wfull) ? r_gnt : '0;
  assign winc     = w_acc;
  assign wdata    = w_busy ? in_data[r_g*DSIZE +: DSIZE] : '0;
  assign words_wr = r_words_wr;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state <= ST_IDLE;
      r_g     <= '0;
      r_p     <= GW'(NREQ - 1);
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_BUSY;
            r_g     <= w_sel;
            r_p     <= w_sel;
            r_gnt   <= w_sel_onehot;
            r_cnt   <= '0;
          end
        end
        default: begin
          if (w_acc) begin
            if (w_end) begin
              r_state <= ST_IDLE;
              r_gnt   <= '0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_words_wr <= '0;
    end else if (w_acc) begin
      r_words_wr <= r_words_wr + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: four word sources driven from a small source model,
// FIFO writes and per-cycle grants logged and compared with hand-derived sequences.
module tb_fifo_wr_arbiter;

  localparam int DSIZE = 8;
  localparam int NREQ  = 4;

  logic                  wclk;
  logic                  wrst_n;
  logic [NREQ-1:0]       in_valid;
  logic [NREQ-1:0]       in_last;
  logic [NREQ*DSIZE-1:0] in_data;
  logic [NREQ-1:0]       in_ready;
  logic [NREQ-1:0]       gnt;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  wfull;
  logic [15:0]           words_wr;

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(16)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_data  (in_data),
    .in_ready (in_ready),
    .gnt      (gnt),
    .winc     (winc),
    .wdata    (wdata),
    .wfull    (wfull),
    .words_wr (words_wr)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_errors = 0;

  // Source model: mode 0 = stream (never last), 1 = last on final word, 2 = every word last.
  int         src_rem  [NREQ];
  int         src_mode [NREQ];
  int         src_idx  [NREQ];
  logic [7:0] src_base [NREQ];

  // Per-cycle observations, indexed from the cycle sampled just before the first edge.
  logic [3:0]  gnt_hist  [64];
  logic        winc_hist [64];
  logic [3:0]  rdy_hist  [64];
  logic [15:0] ww_hist   [64];
  int          n_cyc;
  int          log_req [64];
  logic [7:0]  log_dat [64];
  int          log_n;

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      in_valid[i] = (src_rem[i] != 0);
      in_last[i]  = (src_rem[i] != 0) &&
                    ((src_mode[i] == 2) || (src_mode[i] == 1 && src_rem[i] == 1));
      in_data[i*DSIZE +: DSIZE] = src_base[i] + 8'(src_idx[i]);
    end
  endtask

  task automatic set_src(input int i, input int rem, input int mode, input logic [7:0] base);
    src_rem[i]  = rem;
    src_mode[i] = mode;
    src_idx[i]  = 0;
    src_base[i] = base;
  endtask

  task automatic clear_log();
    n_cyc = 0;
    log_n = 0;
  endtask

  task automatic cycle();
    logic [3:0] v_acc;
    @(negedge wclk);
    if (n_cyc < 64) begin
      gnt_hist[n_cyc]  = gnt;
      winc_hist[n_cyc] = winc;
      rdy_hist[n_cyc]  = in_ready;
      ww_hist[n_cyc]   = words_wr;
    end
    if (winc && log_n < 64) begin
      log_req[log_n] = -1;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) log_req[log_n] = i;
      log_dat[log_n] = wdata;
      log_n++;
    end
    v_acc = in_ready & in_valid;
    n_cyc++;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (v_acc[i]) begin
        src_idx[i]++;
        src_rem[i]--;
      end
    end
    drive();
  endtask

  // Leaves reset asserted at posedge+1; caller loads sources and releases it.
  task automatic do_reset();
    wrst_n = 1'b0;
    wfull  = 1'b0;
    for (int i = 0; i < NREQ; i++) set_src(i, 0, 0, 8'h00);
    drive();
    repeat (2) @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    wfull  = 1'b0;
    for (int i = 0; i < NREQ; i++) set_src(i, 2, 1, 8'h10);
    drive();
    repeat (2) @(negedge wclk);
    n_checks++; if (gnt !== 4'b0000) begin n_errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_ready: got %b expected 0000", in_ready); end
    n_checks++; if (winc !== 1'b0) begin n_errors++; $display("FAIL reset_winc: got %b expected 0", winc); end
    n_checks++; if (wdata !== 8'h00) begin n_errors++; $display("FAIL reset_wdata: got %h expected 00", wdata); end
    n_checks++; if (words_wr !== 16'd0) begin n_errors++; $display("FAIL reset_words_wr: got %0d expected 0", words_wr); end
  endtask

  task automatic test_two_requesters();
    logic [3:0] exp_g [5];
    exp_g = '{4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000};
    do_reset();
    set_src(0, 1, 1, 8'h01);
    set_src(2, 1, 1, 8'h21);
    drive();
    wrst_n = 1'b1;
    clear_log();
    repeat (6) cycle();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (gnt_hist[c] !== exp_g[c]) begin
        n_errors++; $display("FAIL two_req_gnt[%0d]: got %b expected %b", c, gnt_hist[c], exp_g[c]);
      end
    end
    n_checks++; if (log_n !== 2) begin n_errors++; $display("FAIL two_req_winc_count: got %0d expected 2", log_n); end
    n_checks++; if (log_dat[0] !== 8'h01 || log_dat[1] !== 8'h21) begin
      n_errors++; $display("FAIL two_req_data: got %h,%h expected 01,21", log_dat[0], log_dat[1]);
    end
    n_checks++; if (words_wr !== 16'd2) begin n_errors++; $display("FAIL two_req_words_wr: got %0d expected 2", words_wr); end
  endtask

  task automatic test_packet();
    do_reset();
    set_src(2, 5, 1, 8'h20);
    drive();
    wrst_n = 1'b1;
    clear_log();
    repeat (8) cycle();
    for (int c = 1; c <= 5; c++) begin
      n_checks++;
      if (winc_hist[c] !== 1'b1 || gnt_hist[c] !== 4'b0100) begin
        n_errors++; $display("FAIL pkt_beat[%0d]: got winc=%b gnt=%b expected winc=1 gnt=0100", c, winc_hist[c], gnt_hist[c]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (log_dat[k] !== 8'h20 + 8'(k)) begin
        n_errors++; $display("FAIL pkt_data[%0d]: got %h expected %h", k, log_dat[k], 8'h20 + 8'(k));
      end
    end
    n_checks++; if (gnt_hist[6] !== 4'b0000 || winc_hist[6] !== 1'b0) begin
      n_errors++; $display("FAIL pkt_release: got gnt=%b winc=%b expected gnt=0000 winc=0", gnt_hist[6], winc_hist[6]);
    end
    n_checks++; if (words_wr !== 16'd5) begin n_errors++; $display("FAIL pkt_words_wr: got %0d expected 5", words_wr); end
  endtask

  task automatic test_burst_cut();
    int         exp_r;
    logic [7:0] exp_d;
    do_reset();
    set_src(1, 20, 0, 8'h40);
    set_src(3, 1, 1, 8'h70);
    drive();
    wrst_n = 1'b1;
    clear_log();
    repeat (28) cycle();
    n_checks++; if (log_n !== 21) begin n_errors++; $display("FAIL burst_count: got %0d expected 21", log_n); end
    for (int k = 0; k < 21 && k < log_n; k++) begin
      if (k < 16)       begin exp_r = 1; exp_d = 8'h40 + 8'(k); end
      else if (k == 16) begin exp_r = 3; exp_d = 8'h70; end
      else              begin exp_r = 1; exp_d = 8'h50 + 8'(k - 17); end
      n_checks++;
      if (log_req[k] !== exp_r || log_dat[k] !== exp_d) begin
        n_errors++; $display("FAIL burst_word[%0d]: got req%0d data %h expected req%0d data %h", k, log_req[k], log_dat[k], exp_r, exp_d);
      end
    end
    n_checks++; if (gnt_hist[17] !== 4'b0000) begin n_errors++; $display("FAIL burst_cut_idle: got %b expected 0000", gnt_hist[17]); end
    n_checks++; if (gnt !== 4'b0010 || winc !== 1'b0) begin
      n_errors++; $display("FAIL burst_hold_on_invalid: got gnt=%b winc=%b expected gnt=0010 winc=0", gnt, winc);
    end
    n_checks++; if (words_wr !== 16'd21) begin n_errors++; $display("FAIL burst_words_wr: got %0d expected 21", words_wr); end
  endtask

  task automatic test_wfull_stall();
    do_reset();
    set_src(0, 5, 1, 8'h80);
    set_src(1, 1, 1, 8'h90);
    drive();
    wrst_n = 1'b1;
    clear_log();
    for (int c = 0; c < 10; c++) begin
      wfull = (c >= 3 && c <= 5);
      cycle();
    end
    wfull = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      n_checks++;
      if (winc_hist[c] !== 1'b0 || rdy_hist[c] !== 4'b0000 || gnt_hist[c] !== 4'b0001) begin
        n_errors++; $display("FAIL stall[%0d]: got winc=%b ready=%b gnt=%b expected winc=0 ready=0000 gnt=0001",
                             c, winc_hist[c], rdy_hist[c], gnt_hist[c]);
      end
    end
    n_checks++; if (log_n !== 5) begin n_errors++; $display("FAIL stall_count: got %0d expected 5", log_n); end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (log_req[k] !== 0 || log_dat[k] !== 8'h80 + 8'(k)) begin
        n_errors++; $display("FAIL stall_word[%0d]: got req%0d data %h expected req0 data %h", k, log_req[k], log_dat[k], 8'h80 + 8'(k));
      end
    end
    n_checks++; if (winc_hist[8] !== 1'b1 || gnt_hist[9] !== 4'b0000) begin
      n_errors++; $display("FAIL stall_complete: got winc8=%b gnt9=%b expected winc8=1 gnt9=0000", winc_hist[8], gnt_hist[9]);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    set_src(0, 3, 2, 8'hA0);
    set_src(1, 3, 2, 8'hB0);
    set_src(2, 3, 2, 8'hC0);
    set_src(3, 3, 2, 8'hD0);
    drive();
    wrst_n = 1'b1;
    clear_log();
    repeat (18) cycle();
    for (int c = 0; c < 17; c++) begin
      exp_g = (c % 2 == 1) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000;
      n_checks++;
      if (gnt_hist[c] !== exp_g) begin
        n_errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt_hist[c], exp_g);
      end
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (log_req[k] !== k % 4 || log_dat[k] !== src_base[k % 4] + 8'(k / 4)) begin
        n_errors++; $display("FAIL rr_word[%0d]: got req%0d data %h expected req%0d data %h",
                             k, log_req[k], log_dat[k], k % 4, src_base[k % 4] + 8'(k / 4));
      end
    end
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    set_src(2, 5, 1, 8'h30);
    drive();
    wrst_n = 1'b1;
    clear_log();
    repeat (3) cycle();
    n_checks++; if (log_n !== 2 || gnt !== 4'b0100) begin
      n_errors++; $display("FAIL midrst_pre: got words=%0d gnt=%b expected words=2 gnt=0100", log_n, gnt);
    end
    set_src(0, 1, 1, 8'h05);
    drive();
    wrst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000 || winc !== 1'b0 || in_ready !== 4'b0000 || wdata !== 8'h00 || words_wr !== 16'd0) begin
      n_errors++; $display("FAIL midrst_clear: got gnt=%b winc=%b ready=%b wdata=%h words_wr=%0d expected all zero",
                           gnt, winc, in_ready, wdata, words_wr);
    end
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    clear_log();
    repeat (3) cycle();
    n_checks++; if (gnt_hist[1] !== 4'b0001 || winc_hist[1] !== 1'b1 || log_dat[0] !== 8'h05) begin
      n_errors++; $display("FAIL midrst_req0_wins: got gnt=%b winc=%b data=%h expected gnt=0001 winc=1 data=05",
                           gnt_hist[1], winc_hist[1], log_dat[0]);
    end
    n_checks++; if (ww_hist[1] !== 16'd0 || ww_hist[2] !== 16'd1) begin
      n_errors++; $display("FAIL midrst_words_wr: got %0d,%0d expected 0,1", ww_hist[1], ww_hist[2]);
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_src(i, 0, 0, 8'h00);
    n_cyc = 0;
    log_n = 0;
    test_reset();
    test_two_requesters();
    test_packet();
    test_burst_cut();
    test_wfull_stall();
    test_round_robin();
    test_reset_midpacket();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
